command_serial_transmitter: RTL and testbench

//  Upstream partner of the motor-command Receiver. Accepts a 4-bit motor command
//  {Len,Ldir,Ren,Rdir} over a valid/ready handshake and serializes it on Serial_Out.

---
 rtl/command_serial_transmitter.sv | 92 +++++++++
 tb/tb_command_serial_transmitter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/command_serial_transmitter.sv
// command_serial_transmitter: serializes a latched command as start(1-0-1), data MSB first, then a low gap
module command_serial_transmitter #(
    parameter int BIT_CYCLES = 2,
    parameter int DATA_W     = 4,
    parameter int GAP_BITS   = 7
) (
    input  logic              Clk_In,
    input  logic              Reset_In,
    input  logic [DATA_W-1:0] Cmd_In,
    input  logic              Cmd_Valid,
    output logic              Cmd_Ready,
    input  logic              Repeat_En,
    output logic              Serial_Out,
    output logic              Busy,
    output logic              Frame_Done
);
    localparam int M1   = DATA_W > 3 ? DATA_W : 3;
    localparam int MAXB = GAP_BITS > M1 ? GAP_BITS : M1;
    localparam int BW   = $clog2(MAXB);
    localparam int PW   = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(BIT_CYCLES - 1);
    localparam logic [BW-1:0] START_LAST = BW'(2);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] GAP_LAST   = BW'(GAP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, GAP} state_t;

    state_t            state, nxt_state;
    logic [PW-1:0]     pre, nxt_pre;
    logic [BW-1:0]     bit_cnt, nxt_bit;
    logic [DATA_W-1:0] cmd, nxt_cmd, sh, nxt_sh;
    logic              pre_wrap, last_bit, gap_end, accept;

    always_comb begin
        pre_wrap  = pre == PRE_LAST;
        last_bit  = state == START ? bit_cnt == START_LAST :
                    state == DATA  ? bit_cnt == DATA_LAST  : bit_cnt == GAP_LAST;
        gap_end   = state == GAP && last_bit && pre_wrap;
        Cmd_Ready = !Reset_In && (state == IDLE || gap_end);
        accept    = Cmd_Valid && Cmd_Ready;
        nxt_state = state;
        nxt_pre   = pre;
        nxt_bit   = bit_cnt;
        nxt_cmd   = cmd;
        nxt_sh    = sh;
        if (state == IDLE) begin
            if (accept) begin
                nxt_state = START;
                nxt_cmd   = Cmd_In;
            end
        end else begin
            nxt_pre = pre_wrap ? '0 : pre + PW'(1);
            if (pre_wrap) begin
                nxt_bit = last_bit ? '0 : bit_cnt + BW'(1);
                if (state == DATA && !last_bit)
                    nxt_sh = sh << 1;
                if (last_bit) begin
                    // a fresh command in the last gap cycle outranks repeating the old one
                    nxt_state = state == START ? DATA :
                                state == DATA  ? GAP  :
                                (accept || Repeat_En) ? START : IDLE;
                    if (state == START)
                        nxt_sh = cmd;
                    if (gap_end && accept)
                        nxt_cmd = Cmd_In;
                end
            end
        end
    end

    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            state      <= IDLE;
            pre        <= '0;
            bit_cnt    <= '0;
            cmd        <= '0;
            sh         <= '0;
            Serial_Out <= 1'b0;
            Busy       <= 1'b0;
            Frame_Done <= 1'b0;
        end else begin
            state      <= nxt_state;
            pre        <= nxt_pre;
            bit_cnt    <= nxt_bit;
            cmd        <= nxt_cmd;
            sh         <= nxt_sh;
            Serial_Out <= nxt_state == START ? ~nxt_bit[0] : nxt_state == DATA && nxt_sh[DATA_W-1];
            Busy       <= nxt_state != IDLE;
            Frame_Done <= nxt_state == GAP && nxt_bit == GAP_LAST && nxt_pre == PRE_LAST;
        end
    end
endmodule

// File: tb/tb_command_serial_transmitter.sv
// tb_command_serial_transmitter: frame-position reference model checked every cycle against the transmitter
module tb_command_serial_transmitter;
    localparam int BC = 2;
    localparam int FL = 28;

    logic       clk = 1'b0, rst = 1'b1, valid = 1'b0, rep = 1'b0;
    logic [3:0] cin = 4'd0;
    logic       Cmd_Ready, Serial_Out, Busy, Frame_Done;

    int         total = 0, bad = 0;
    int         p = 0;
    logic       act = 1'b0;
    logic [3:0] cur = 4'd0;

    command_serial_transmitter dut (
        .Clk_In(clk), .Reset_In(rst), .Cmd_In(cin), .Cmd_Valid(valid),
        .Cmd_Ready(Cmd_Ready), .Repeat_En(rep), .Serial_Out(Serial_Out),
        .Busy(Busy), .Frame_Done(Frame_Done)
    );

    always #5 clk = ~clk;

    function automatic logic exp_ser(int pp, logic [3:0] c);
        logic pat [14];
        pat = '{1'b1, 1'b0, 1'b1, c[3], c[2], c[1], c[0],
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        return pat[pp / BC];
    endfunction

    task automatic chk(string tag, logic o, logic e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b t=%0t", tag, o, e, $time);
        end
    endtask

    task automatic cyc();
        logic er, acc;
        @(negedge clk);
        er = !rst && (!act || p == FL - 1);
        chk("cmd_ready", Cmd_Ready, er);
        acc = valid && er;
        @(posedge clk);
        if (rst) begin
            act = 1'b0; p = 0; cur = 4'd0;
        end else if (act && p < FL - 1) begin
            p++;
        end else if (acc) begin
            act = 1'b1; p = 0; cur = cin;
        end else if (act && rep) begin
            p = 0;
        end else begin
            act = 1'b0; p = 0;
        end
        #1;
        chk("serial_out", Serial_Out, act && exp_ser(p, cur));
        chk("busy", Busy, act);
        chk("frame_done", Frame_Done, act && p == FL - 1);
    endtask

    task automatic run(int n);
        repeat (n) cyc();
    endtask

    task automatic until_p(int t);
        for (int k = 0; k < 100 && !(act && p == t); k++) cyc();
        if (!(act && p == t)) begin
            total++;
            bad++;
            $error("FAIL wait_pos obs=%0d exp=%0d", p, t);
        end
    endtask

    initial begin
        run(3);
        rst = 1'b0;
        cyc();
        cin = 4'b1010; valid = 1'b1;
        cyc();
        valid = 1'b0;
        run(32);
        rep = 1'b1; cin = 4'b0110; valid = 1'b1;
        cyc();
        valid = 1'b0;
        repeat (60) begin
            cin = 4'($urandom);
            cyc();
        end
        until_p(FL - 2);
        cin = 4'b0011; valid = 1'b1;
        cyc();
        cin = 4'b1111;
        cyc();
        valid = 1'b0;
        until_p(FL - 2);
        cin = 4'b1001; valid = 1'b1;
        cyc();
        valid = 1'b0;
        run(30);
        rep = 1'b0;
        run(60);
        cin = 4'b0001; valid = 1'b1;
        cyc();
        valid = 1'b0;
        until_p(8);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cin = 4'b0001; valid = 1'b1;
        cyc();
        valid = 1'b0;
        run(30);
        repeat (1500) begin
            valid = $urandom_range(0, 3) == 0;
            cin   = 4'($urandom);
            if ($urandom_range(0, 49) == 0) rep = 1'($urandom);
            rst   = $urandom_range(0, 299) == 0;
            cyc();
        end
        rst = 1'b0; valid = 1'b0;
        run(60);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
